axis_keep_mask_reg: RTL and testbench
=====================================

# axis_keep_mask_reg

Registered, parametrised AXI4-Stream byte-lane masking stage. Each accepted beat has its null lanes (tkeep bit = 0) overwritten with a fill byte. Optionally, non-last all-null beats are dropped, and per-packet valid-byte counts are reported. The block sits in the same stream paths as the combinational keep-zero mask. It adds a full-throughput skid buffer so it can break long timing paths between DMA and the DRAM-command datapath.

## Interface
Parameters:
- TDATA_WIDTH, 32, data width in bits; must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8, bits per lane.
- TKEEP_WIDTH, TDATA_WIDTH/BYTE_WIDTH, lane count.
- TUSER_WIDTH, 1, sideband width, passed through unmodified.
- FILL_VALUE, 0, BYTE_WIDTH-bit value written into null lanes.
- DROP_NULL, 0, 1 = discard accepted beats with tkeep==0 and tlast==0.
- COUNT_WIDTH, 16, width of the packet byte counter.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset; one clock, asynchronous assert, active-low.
- mask_en  in  1  1 = apply fill, 0 = data passes unmasked; sampled per beat at input acceptance.
- s_axis_tdata  in  TDATA_WIDTH  input data.
- s_axis_tkeep  in  TKEEP_WIDTH  input lane qualifiers.
- s_axis_tuser  in  TUSER_WIDTH  sideband.
- s_axis_tlast  in  1  end of packet.
- s_axis_tvalid  in  1  input valid.
- s_axis_tready  out  1  input ready.
- m_axis_tdata  out  TDATA_WIDTH  masked data.
- m_axis_tkeep  out  TKEEP_WIDTH  equal to the input tkeep of the same beat.
- m_axis_tuser  out  TUSER_WIDTH  equal to the input tuser of the same beat.
- m_axis_tlast  out  1  equal to the input tlast of the same beat.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.
- pkt_bytes  out  COUNT_WIDTH  valid-lane count of the last completed packet.
- pkt_done  out  1  one-cycle pulse; pkt_bytes is updated in the same cycle.
- err_null  out  1  one-cycle pulse per accepted beat with tkeep==0, whether or not the beat is dropped.

## Operation
- Input acceptance: s_axis_tvalid && s_axis_tready.
- Masking: for each lane i:
  - out lane = tdata lane when tkeep[i]=1 or mask_en=0;
  - out lane = FILL_VALUE otherwise.
- Masking is applied before the skid buffer; the buffer stores already-masked data.
- Drop rule: with DROP_NULL=1, an accepted beat with tkeep==0 and tlast==0 is consumed (input ready honoured) and not written to the buffer.
- A null beat with tlast=1 is always forwarded, so packet boundaries are preserved.
- Byte counter: an accumulator adds popcount(tkeep) for every accepted beat, dropped beats included (they add 0).
- Counter saturates at 2^COUNT_WIDTH-1; no wrap.
- On acceptance of a tlast beat:
  - pkt_bytes <= accumulator + popcount(tkeep), saturated;
  - pkt_done is asserted for the next cycle;
  - accumulator clears to 0.
- Counting is on the input side; pkt_done may precede emission of the last output beat.
- Skid buffer: two entries, main (drives m_axis_*) and skid.
- Buffer states:
  - EMPTY: both entries invalid.
  - ONE: main valid.
  - FULL: main and skid valid.
- Buffer transitions:
  - EMPTY→ONE on a write.
  - ONE→EMPTY on a read with no write.
  - ONE→FULL on a write with no read.
  - ONE stays ONE on a simultaneous read and write (main reloads).
  - FULL→ONE on a read: skid moves to main.
- s_axis_tready is a registered flop; it is 1 when the buffer is not FULL.
- s_axis_tready has no combinational path from m_axis_tready.

## Timing
- Reset (aresetn=0), all outputs:
  - m_axis_tvalid=0, s_axis_tready=0;
  - pkt_done=0, err_null=0, pkt_bytes=0;
  - m_axis_tdata/tkeep/tuser/tlast=0.
- Reset internals: accumulator=0, buffer EMPTY.
- Release: s_axis_tready rises on the first aclk edge after aresetn deasserts.
- Latency: a beat accepted at edge N appears on m_axis_* after edge N (1 cycle).
- Throughput: 1 beat/cycle with m_axis_tready held at 1.
- Back-pressure:
  - m_axis_tready=0 for ≥2 cycles fills the skid entry;
  - s_axis_tready drops the cycle after the second beat is stored;
  - no beat is lost or duplicated.
- m_axis_* hold stable while m_axis_tvalid=1 and m_axis_tready=0.
- Reset mid-packet:
  - in-flight beats are discarded;
  - accumulator is cleared;
  - no pkt_done is issued for the aborted packet.
- err_null and pkt_done assert one cycle after the triggering acceptance.

## Structure
- Package axis_mask_pkg:
  - popcount function over TKEEP_WIDTH;
  - lane-mask expansion function (tkeep → TDATA_WIDTH mask, BYTE_WIDTH bits per lane);
  - buffer state encoding constants (EMPTY/ONE/FULL).
- Sub-module axis_skid_buffer:
  - generic over payload width (TDATA+TKEEP+TUSER+1);
  - instantiated once;
  - owns tready/tvalid registration.
- Top level holds only masking, drop logic, counter and error pulse.

## Test plan
- Reset, defaults: TDATA_WIDTH=32, FILL_VALUE=0, mask_en=1, m_axis_tready=1. Send tdata=0xAABBCCDD, tkeep=4'b0011, tlast=1 → one cycle later m_axis_tdata=0x0000CCDD, tkeep=4'b0011; pkt_done=1, pkt_bytes=2.
- FILL_VALUE=0x5A, tkeep=4'b1010, tdata=0x11223344 → 0x115A335A. Same beat with mask_en=0 → 0x11223344.
- DROP_NULL=1, packet = {tkeep=F}, {tkeep=0, tlast=0}, {tkeep=0, tlast=1} → two output beats (F, then 0 with tlast); err_null pulses twice; pkt_bytes=4.
- Random tvalid and random m_axis_tready (50%) over 10k beats → output stream equals reference-model stream; s_axis_tready never depends combinationally on m_axis_tready; no drops or duplicates.
- COUNT_WIDTH=4, single 5-beat packet with tkeep=F → pkt_bytes saturates at 15.
- Assert aresetn mid-packet with the buffer FULL → m_axis_tvalid=0 immediately. The next full packet {tkeep=F, tlast=1} reports pkt_bytes=4.

Source files
------------

// File: rtl/axis_mask_pkg.sv
// Shared helpers for the AXI4-Stream keep-mask stage: lane arithmetic and
// skid-buffer state encoding.
package axis_mask_pkg;

   localparam int unsigned MAX_LANES = 1024;
   localparam int unsigned MAX_BITS  = 1024;

   localparam logic [1:0] BUF_EMPTY = 2'd0;
   localparam logic [1:0] BUF_ONE   = 2'd1;
   localparam logic [1:0] BUF_FULL  = 2'd2;

   function automatic logic [15:0] popcount(input logic [MAX_LANES-1:0] keep);
      logic [15:0] cnt;
      cnt = '0;
      for (int i = 0; i < MAX_LANES; i++) begin
         cnt = cnt + 16'(keep[i]);
      end
      return cnt;
   endfunction

   // Callers zero-extend tkeep and truncate the result to their data width.
   function automatic logic [MAX_BITS-1:0] lane_mask(input logic [MAX_LANES-1:0] keep,
                                                     input int unsigned byte_width);
      logic [MAX_BITS-1:0] mask;
      mask = '0;
      for (int i = 0; i < MAX_BITS; i++) begin
         mask[i] = keep[i / byte_width];
      end
      return mask;
   endfunction

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry full-throughput skid buffer; ready is a flop with no path from
// the downstream ready.
module axis_skid_buffer
   import axis_mask_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready
);

   logic [1:0]       state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             ready_q;
   logic             wr, rd;

   assign wr = in_valid && ready_q;
   assign rd = (state_q != BUF_EMPTY) && out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         BUF_EMPTY: begin
            if (wr) begin
               main_d  = in_data;
               state_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (wr && rd) begin
               main_d = in_data;
            end else if (wr) begin
               skid_d  = in_data;
               state_d = BUF_FULL;
            end else if (rd) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_FULL: begin
            if (rd) begin
               main_d  = skid_q;
               state_d = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= BUF_EMPTY;
         main_q  <= '0;
         skid_q  <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         ready_q <= (state_d != BUF_FULL);
      end
   end

   assign in_ready  = ready_q;
   assign out_data  = main_q;
   assign out_valid = (state_q != BUF_EMPTY);

endmodule

// File: rtl/axis_keep_mask_reg.sv
// Registered AXI4-Stream byte-lane mask: fills null lanes, optionally drops
// non-last null beats, and reports per-packet valid-byte counts.
module axis_keep_mask_reg
   import axis_mask_pkg::*;
#(
   parameter int unsigned         TDATA_WIDTH = 32,
   parameter int unsigned         BYTE_WIDTH  = 8,
   parameter int unsigned         TKEEP_WIDTH = TDATA_WIDTH / BYTE_WIDTH,
   parameter int unsigned         TUSER_WIDTH = 1,
   parameter logic [BYTE_WIDTH-1:0] FILL_VALUE = '0,
   parameter bit                  DROP_NULL   = 1'b0,
   parameter int unsigned         COUNT_WIDTH = 16
) (
   input  logic                   aclk,
   input  logic                   aresetn,
   input  logic                   mask_en,
   input  logic [TDATA_WIDTH-1:0] s_axis_tdata,
   input  logic [TKEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic [TUSER_WIDTH-1:0] s_axis_tuser,
   input  logic                   s_axis_tlast,
   input  logic                   s_axis_tvalid,
   output logic                   s_axis_tready,
   output logic [TDATA_WIDTH-1:0] m_axis_tdata,
   output logic [TKEEP_WIDTH-1:0] m_axis_tkeep,
   output logic [TUSER_WIDTH-1:0] m_axis_tuser,
   output logic                   m_axis_tlast,
   output logic                   m_axis_tvalid,
   input  logic                   m_axis_tready,
   output logic [COUNT_WIDTH-1:0] pkt_bytes,
   output logic                   pkt_done,
   output logic                   err_null
);

   localparam int unsigned PAYLOAD_W = TDATA_WIDTH + TKEEP_WIDTH + TUSER_WIDTH + 1;
   localparam int unsigned SUM_W     = COUNT_WIDTH + 17;

   logic [TDATA_WIDTH-1:0] lanes_on, fill_data, masked;
   logic                   accept, is_null, drop, wr_valid;
   logic [PAYLOAD_W-1:0]   in_payload, out_payload;
   logic [SUM_W-1:0]       sum_wide;
   logic [COUNT_WIDTH-1:0] sum_sat;
   logic [COUNT_WIDTH-1:0] acc_q, pkt_bytes_q;
   logic                   pkt_done_q, err_null_q;

   assign lanes_on  = TDATA_WIDTH'(lane_mask(MAX_LANES'(s_axis_tkeep), BYTE_WIDTH));
   assign fill_data = {TKEEP_WIDTH{FILL_VALUE}};
   assign masked    = mask_en ? ((s_axis_tdata & lanes_on) | (fill_data & ~lanes_on))
                              : s_axis_tdata;

   assign accept   = s_axis_tvalid && s_axis_tready;
   assign is_null  = (s_axis_tkeep == '0);
   // A null beat carrying tlast still goes out so the packet boundary survives.
   assign drop     = DROP_NULL && is_null && !s_axis_tlast;
   assign wr_valid = s_axis_tvalid && !drop;

   assign in_payload = {masked, s_axis_tkeep, s_axis_tuser, s_axis_tlast};

   axis_skid_buffer #(
      .WIDTH (PAYLOAD_W)
   ) u_skid (
      .clk       (aclk),
      .rst_n     (aresetn),
      .in_data   (in_payload),
      .in_valid  (wr_valid),
      .in_ready  (s_axis_tready),
      .out_data  (out_payload),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

   assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_payload;

   assign sum_wide = SUM_W'(acc_q) + SUM_W'(popcount(MAX_LANES'(s_axis_tkeep)));
   assign sum_sat  = (sum_wide > SUM_W'({COUNT_WIDTH{1'b1}})) ? '1
                                                             : sum_wide[COUNT_WIDTH-1:0];

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         acc_q       <= '0;
         pkt_bytes_q <= '0;
         pkt_done_q  <= 1'b0;
         err_null_q  <= 1'b0;
      end else begin
         pkt_done_q <= 1'b0;
         err_null_q <= accept && is_null;
         if (accept) begin
            if (s_axis_tlast) begin
               pkt_bytes_q <= sum_sat;
               pkt_done_q  <= 1'b1;
               acc_q       <= '0;
            end else begin
               acc_q <= sum_sat;
            end
         end
      end
   end

   assign pkt_bytes = pkt_bytes_q;
   assign pkt_done  = pkt_done_q;
   assign err_null  = err_null_q;

endmodule

// File: tb/tb_axis_keep_mask_reg.sv
// Bench for axis_keep_mask_reg: two instances (default and fill/drop/narrow
// counter) share stimulus and are scored against a lane-level reference model.
module tb_axis_keep_mask_reg;

   typedef struct packed {
      logic [31:0] data;
      logic [3:0]  keep;
      logic [0:0]  user;
      logic        last;
   } beat_t;

   typedef struct {
      logic        en;
      logic [31:0] data;
      logic [3:0]  keep;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      int          bytes;
   } vec_t;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        mask_en = 1'b1;
   logic [31:0] s_tdata = '0;
   logic [3:0]  s_tkeep = '0;
   logic [0:0]  s_tuser = '0;
   logic        s_tlast = 1'b0;
   logic        s_tvalid = 1'b0;
   logic        m_tready = 1'b0;

   logic        s_tready_a, m_tvalid_a, m_tlast_a, pkt_done_a, err_null_a;
   logic [31:0] m_tdata_a;
   logic [3:0]  m_tkeep_a;
   logic [0:0]  m_tuser_a;
   logic [15:0] pkt_bytes_a;

   logic        s_tready_b, m_tvalid_b, m_tlast_b, pkt_done_b, err_null_b;
   logic [31:0] m_tdata_b;
   logic [3:0]  m_tkeep_b;
   logic [0:0]  m_tuser_b;
   logic [3:0]  pkt_bytes_b;

   int checks = 0;
   int errors = 0;

   always #5 aclk = ~aclk;

   axis_keep_mask_reg u_dut_a (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .mask_en       (mask_en),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tuser  (s_tuser),
      .s_axis_tlast  (s_tlast),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready_a),
      .m_axis_tdata  (m_tdata_a),
      .m_axis_tkeep  (m_tkeep_a),
      .m_axis_tuser  (m_tuser_a),
      .m_axis_tlast  (m_tlast_a),
      .m_axis_tvalid (m_tvalid_a),
      .m_axis_tready (m_tready),
      .pkt_bytes     (pkt_bytes_a),
      .pkt_done      (pkt_done_a),
      .err_null      (err_null_a)
   );

   axis_keep_mask_reg #(
      .FILL_VALUE  (8'h5A),
      .DROP_NULL   (1'b1),
      .COUNT_WIDTH (4)
   ) u_dut_b (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .mask_en       (mask_en),
      .s_axis_tdata  (s_tdata),
      .s_axis_tkeep  (s_tkeep),
      .s_axis_tuser  (s_tuser),
      .s_axis_tlast  (s_tlast),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready_b),
      .m_axis_tdata  (m_tdata_b),
      .m_axis_tkeep  (m_tkeep_b),
      .m_axis_tuser  (m_tuser_b),
      .m_axis_tlast  (m_tlast_b),
      .m_axis_tvalid (m_tvalid_b),
      .m_axis_tready (m_tready),
      .pkt_bytes     (pkt_bytes_b),
      .pkt_done      (pkt_done_b),
      .err_null      (err_null_b)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int unsigned fill_of(input int d);
      return (d == 0) ? 0 : 'h5A;
   endfunction

   function automatic int cmax_of(input int d);
      return (d == 0) ? 65535 : 15;
   endfunction

   function automatic logic [31:0] model_mask(input logic [31:0] data, input logic [3:0] keep,
                                              input logic en, input int d);
      logic [31:0] r;
      logic [7:0]  b;
      r = '0;
      for (int i = 0; i < 4; i++) begin
         b = 8'((data >> (8 * i)) & 32'hFF);
         if (en && !keep[i]) b = 8'(fill_of(d));
         r = r | (32'(b) << (8 * i));
      end
      return r;
   endfunction

   // Per-instance views for the scoreboard.
   logic        o_valid [2];
   logic        o_ready [2];
   logic        o_done  [2];
   logic        o_err   [2];
   logic [15:0] o_bytes [2];
   beat_t       o_beat  [2];
   assign o_valid[0] = m_tvalid_a;
   assign o_valid[1] = m_tvalid_b;
   assign o_ready[0] = s_tready_a;
   assign o_ready[1] = s_tready_b;
   assign o_done[0]  = pkt_done_a;
   assign o_done[1]  = pkt_done_b;
   assign o_err[0]   = err_null_a;
   assign o_err[1]   = err_null_b;
   assign o_bytes[0] = pkt_bytes_a;
   assign o_bytes[1] = 16'(pkt_bytes_b);
   assign o_beat[0]  = {m_tdata_a, m_tkeep_a, m_tuser_a, m_tlast_a};
   assign o_beat[1]  = {m_tdata_b, m_tkeep_b, m_tuser_b, m_tlast_b};

   beat_t mq [2][64];
   int    head [2];
   int    tail [2];
   int    acc_m [2];
   int    exp_bytes [2];
   logic  exp_done [2];
   logic  exp_err [2];
   logic  rdy_snap [2];

   initial begin
      for (int d = 0; d < 2; d++) begin
         head[d] = 0; tail[d] = 0; acc_m[d] = 0; exp_bytes[d] = 0;
         exp_done[d] = 1'b0; exp_err[d] = 1'b0; rdy_snap[d] = 1'b0;
      end
   end

   always @(posedge aclk) begin
      #1;
      rdy_snap[0] = s_tready_a;
      rdy_snap[1] = s_tready_b;
   end

   // Inputs change on the falling edge; at +1 they are exactly what the next
   // rising edge will act on, so handshakes are scored here.
   always @(negedge aclk) begin : mon
      int    pop;
      beat_t nb;
      logic  nul;
      #1;
      for (int d = 0; d < 2; d++) begin
         if (!aresetn) begin
            chk($sformatf("rst_tvalid[%0d]", d), 64'(o_valid[d]), 64'd0);
            chk($sformatf("rst_tready[%0d]", d), 64'(o_ready[d]), 64'd0);
            head[d] = 0; tail[d] = 0; acc_m[d] = 0; exp_bytes[d] = 0;
            exp_done[d] = 1'b0; exp_err[d] = 1'b0;
         end else begin
            chk($sformatf("pkt_done[%0d]", d), 64'(o_done[d]), 64'(exp_done[d]));
            chk($sformatf("err_null[%0d]", d), 64'(o_err[d]), 64'(exp_err[d]));
            chk($sformatf("pkt_bytes[%0d]", d), 64'(o_bytes[d]), 64'(exp_bytes[d]));
            chk($sformatf("tready_reg[%0d]", d), 64'(o_ready[d]), 64'(rdy_snap[d]));
            if (o_valid[d] && m_tready) begin
               chk($sformatf("beat_expected[%0d]", d), 64'(head[d] != tail[d]), 64'd1);
               if (head[d] != tail[d]) begin
                  chk($sformatf("beat[%0d]", d), 64'(o_beat[d]), 64'(mq[d][head[d] % 64]));
                  head[d]++;
               end
            end
            exp_done[d] = 1'b0;
            exp_err[d]  = 1'b0;
            if (s_tvalid && o_ready[d]) begin
               pop = 0;
               for (int i = 0; i < 4; i++) pop += int'(s_tkeep[i]);
               nul = (s_tkeep == 4'h0);
               exp_err[d] = nul;
               acc_m[d] = (acc_m[d] + pop > cmax_of(d)) ? cmax_of(d) : acc_m[d] + pop;
               if (s_tlast) begin
                  exp_bytes[d] = acc_m[d];
                  exp_done[d]  = 1'b1;
                  acc_m[d]     = 0;
               end
               if (!(d == 1 && nul && !s_tlast)) begin
                  nb.data = model_mask(s_tdata, s_tkeep, mask_en, d);
                  nb.keep = s_tkeep;
                  nb.user = s_tuser;
                  nb.last = s_tlast;
                  mq[d][tail[d] % 64] = nb;
                  tail[d]++;
               end
            end
         end
      end
   end

   task automatic send(input logic en, input logic [31:0] data, input logic [3:0] keep,
                       input logic last);
      @(negedge aclk);
      mask_en  = en;
      s_tdata  = data;
      s_tkeep  = keep;
      s_tlast  = last;
      s_tuser  = 1'($urandom);
      s_tvalid = 1'b1;
   endtask

   task automatic idle();
      @(negedge aclk);
      s_tvalid = 1'b0;
   endtask

   vec_t vecs [6];
   vec_t v;
   int   n_a, n_b, e_b, w;
   logic [3:0] lk_b;
   logic       ll_b;

   initial begin
      vecs[0] = '{1'b1, 32'hAABBCCDD, 4'b0011, 32'h0000CCDD, 32'h5A5ACCDD, 2};
      vecs[1] = '{1'b1, 32'h11223344, 4'b1010, 32'h11003300, 32'h115A335A, 2};
      vecs[2] = '{1'b0, 32'h11223344, 4'b1010, 32'h11223344, 32'h11223344, 2};
      vecs[3] = '{1'b1, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF, 32'hDEADBEEF, 4};
      vecs[4] = '{1'b1, 32'h12345678, 4'b0000, 32'h00000000, 32'h5A5A5A5A, 0};
      vecs[5] = '{1'b1, 32'h12345678, 4'b0001, 32'h00000078, 32'h5A5A5A78, 1};

      repeat (3) @(negedge aclk);
      #2;
      chk("rst_tdata_a", 64'(m_tdata_a), 64'd0);
      chk("rst_tkeep_a", 64'(m_tkeep_a), 64'd0);
      chk("rst_tlast_b", 64'(m_tlast_b), 64'd0);
      chk("rst_pkt_bytes_a", 64'(pkt_bytes_a), 64'd0);
      chk("rst_pkt_done_a", 64'(pkt_done_a), 64'd0);
      chk("rst_err_null_b", 64'(err_null_b), 64'd0);

      @(negedge aclk);
      aresetn  = 1'b1;
      m_tready = 1'b1;
      @(negedge aclk);
      #2;
      chk("release_tready_a", 64'(s_tready_a), 64'd1);
      chk("release_tready_b", 64'(s_tready_b), 64'd1);

      // Single-beat packets with one-cycle latency.
      for (int i = 0; i < 6; i++) begin
         v = vecs[i];
         send(v.en, v.data, v.keep, 1'b1);
         idle();
         #2;
         chk($sformatf("vec%0d_tvalid_a", i), 64'(m_tvalid_a), 64'd1);
         chk($sformatf("vec%0d_tdata_a", i), 64'(m_tdata_a), 64'(v.exp_a));
         chk($sformatf("vec%0d_tdata_b", i), 64'(m_tdata_b), 64'(v.exp_b));
         chk($sformatf("vec%0d_tkeep_a", i), 64'(m_tkeep_a), 64'(v.keep));
         chk($sformatf("vec%0d_tlast_b", i), 64'(m_tlast_b), 64'd1);
         chk($sformatf("vec%0d_done_a", i), 64'(pkt_done_a), 64'd1);
         chk($sformatf("vec%0d_bytes_a", i), 64'(pkt_bytes_a), 64'(v.bytes));
         chk($sformatf("vec%0d_bytes_b", i), 64'(pkt_bytes_b), 64'(v.bytes));
         chk($sformatf("vec%0d_err_a", i), 64'(err_null_a), 64'(v.keep == 4'h0));
         idle();
      end

      // Null-beat dropping: F, 0, 0+last.
      n_a = 0; n_b = 0; e_b = 0; lk_b = 4'hF; ll_b = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge aclk);
         s_tvalid = (c < 3);
         s_tlast  = (c == 2);
         s_tkeep  = (c == 0) ? 4'hF : 4'h0;
         s_tdata  = 32'hCAFE0000 + 32'(c);
         mask_en  = 1'b1;
         #2;
         if (m_tvalid_a) n_a++;
         if (m_tvalid_b) begin
            n_b++;
            lk_b = m_tkeep_b;
            ll_b = m_tlast_b;
         end
         if (err_null_b) e_b++;
      end
      chk("drop_beats_a", 64'(n_a), 64'd3);
      chk("drop_beats_b", 64'(n_b), 64'd2);
      chk("drop_err_b", 64'(e_b), 64'd2);
      chk("drop_lastkeep_b", 64'(lk_b), 64'd0);
      chk("drop_lastflag_b", 64'(ll_b), 64'd1);
      chk("drop_bytes_b", 64'(pkt_bytes_b), 64'd4);

      // Saturation of the narrow counter over a 5-beat packet.
      for (int i = 0; i < 5; i++) send(1'b1, 32'h01020304, 4'hF, (i == 4));
      idle();
      #2;
      chk("sat_bytes_b", 64'(pkt_bytes_b), 64'd15);
      chk("sat_bytes_a", 64'(pkt_bytes_a), 64'd20);
      chk("sat_done_b", 64'(pkt_done_b), 64'd1);
      idle();

      // Fill both entries, then reset mid-packet.
      @(negedge aclk);
      m_tready = 1'b0;
      for (int i = 0; i < 4; i++) send(1'b1, 32'h0BAD0000 + 32'(i), 4'hF, 1'b0);
      idle();
      #2;
      chk("full_tvalid_a", 64'(m_tvalid_a), 64'd1);
      chk("full_tready_a", 64'(s_tready_a), 64'd0);
      @(negedge aclk);
      aresetn = 1'b0;
      #1;
      chk("midrst_tvalid_a", 64'(m_tvalid_a), 64'd0);
      chk("midrst_tvalid_b", 64'(m_tvalid_b), 64'd0);
      repeat (2) @(negedge aclk);
      aresetn  = 1'b1;
      m_tready = 1'b1;
      w = 0;
      while (!s_tready_a && w < 10) begin
         @(negedge aclk);
         w++;
      end
      chk("ready_after_reset", 64'(s_tready_a), 64'd1);
      send(1'b1, 32'h55667788, 4'hF, 1'b1);
      idle();
      #2;
      chk("postrst_bytes_a", 64'(pkt_bytes_a), 64'd4);
      chk("postrst_bytes_b", 64'(pkt_bytes_b), 64'd4);
      chk("postrst_done_a", 64'(pkt_done_a), 64'd1);

      // Random traffic with random back-pressure, scored by the monitor.
      for (int c = 0; c < 30000; c++) begin
         @(negedge aclk);
         s_tvalid = 1'($urandom_range(0, 1));
         m_tready = 1'($urandom_range(0, 1));
         mask_en  = ($urandom_range(0, 3) != 0);
         s_tdata  = $urandom;
         s_tkeep  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         s_tuser  = 1'($urandom);
         s_tlast  = ($urandom_range(0, 3) == 0);
      end
      @(negedge aclk);
      s_tvalid = 1'b0;
      m_tready = 1'b1;
      repeat (6) @(negedge aclk);
      #2;
      chk("drain_a", 64'(tail[0] - head[0]), 64'd0);
      chk("drain_b", 64'(tail[1] - head[1]), 64'd0);
      chk("drain_tvalid_a", 64'(m_tvalid_a), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
